// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and helpers for the two-master Wishbone arbiter.
//               Holds the arbiter state encoding, the one-hot grant codes and
//               the watchdog counter width function.
// Revision    : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

   // Counter must hold 0..timeout. A disabled watchdog (timeout 0) still
   // gets a 1-bit width so that no zero-width vectors are ever declared.
   function automatic int wdt_width(input int timeout);
      if (timeout < 1) begin
         return 1;
      end
      return $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : Stalled-strobe watchdog. Counts consecutive cycles in which a
//               strobe is outstanding without an ack and raises a one-cycle
//               fire pulse on the TIMEOUT_CYCLES-th such cycle.
// Ports       : clk      - clock
//               rst_n    - synchronous active-low reset
//               i_stall  - strobe outstanding this cycle
//               i_ack    - slave ack this cycle (always beats a fire)
//               i_clear  - owner is leaving, restart the count
//               o_fire   - combinational fire pulse
// Revision    : 1.0  initial release
// ============================================================================
module wb_watchdog
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_stall,
   input  logic i_ack,
   input  logic i_clear,
   output logic o_fire
);

   localparam int c_CNT_W = wdt_width(TIMEOUT_CYCLES);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdt_on
         localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

         logic [c_CNT_W-1:0] r_cnt;
         logic               w_fire;

         // The count equals the number of stalled cycles already elapsed, so
         // hitting TIMEOUT-1 while still stalled is the TIMEOUT-th one.
         assign w_fire = i_stall && !i_ack && (r_cnt == c_LAST);

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (i_clear || !i_stall || i_ack || w_fire) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
         end

         assign o_fire = w_fire;
      end else begin : g_wdt_off
         logic w_unused;
         assign w_unused = &{1'b0, clk, rst_n, i_stall, i_ack, i_clear};
         assign o_fire   = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_dual_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_dual_master_arbiter
// Description : Two-master Wishbone classic arbiter. Master 0 is instruction
//               fetch, master 1 is load/store. Round-robin on contention, the
//               owner keeps the bus while cyc stays high, one DRAIN bubble
//               after every release, and a watchdog that errors a hung cycle.
// Ports       : clk, rst_n           - clock, synchronous active-low reset
//               m0_*_i / m0_*_o      - master 0 (fetch) Wishbone port
//               m1_*_i / m1_*_o      - master 1 (data) Wishbone port
//               s_*_o / s_*_i        - shared slave Wishbone port
//               grant_o              - one-hot current owner
//               timeout_o            - one-cycle pulse when the watchdog fires
// Revision    : 1.0  initial release
// ============================================================================
module wb_dual_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_WIDTH      = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [SEL_WIDTH-1:0]  m0_sel_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_data_i,
   output logic [DATA_WIDTH-1:0] m0_data_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [SEL_WIDTH-1:0]  m1_sel_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_data_i,
   output logic [DATA_WIDTH-1:0] m1_data_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [SEL_WIDTH-1:0]  s_sel_o,
   output logic [ADDR_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_data_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_ack_i,
   output logic [1:0]            grant_o,
   output logic                  timeout_o
);

   arb_state_t r_state;
   logic [1:0] r_grant;
   logic [1:0] r_last_grant;

   logic w_req0;
   logic w_req1;
   logic w_owned;
   logic w_owner_cyc;
   logic w_fire;

   assign w_req0      = m0_cyc_i & m0_stb_i;
   assign w_req1      = m1_cyc_i & m1_stb_i;
   assign w_owned     = (r_state == OWN0) || (r_state == OWN1);
   assign w_owner_cyc = (r_state == OWN0) ? m0_cyc_i : m1_cyc_i;

   wb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_stall (w_owned && s_stb_o),
      .i_ack   (s_ack_i),
      .i_clear (w_owned && !w_owner_cyc),
      .o_fire  (w_fire)
   );

   // Arbitration FSM. Grant and last-owner are registered alongside the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_grant      <= GNT_NONE;
         r_last_grant <= GNT_M1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req0 && (!w_req1 || r_last_grant == GNT_M1)) begin
                  r_state <= OWN0;
                  r_grant <= GNT_M0;
               end else if (w_req1) begin
                  r_state <= OWN1;
                  r_grant <= GNT_M1;
               end
            end
            OWN0: begin
               if (!m0_cyc_i || w_fire) begin
                  r_state      <= DRAIN;
                  r_grant      <= GNT_NONE;
                  r_last_grant <= GNT_M0;
               end
            end
            OWN1: begin
               if (!m1_cyc_i || w_fire) begin
                  r_state      <= DRAIN;
                  r_grant      <= GNT_NONE;
                  r_last_grant <= GNT_M1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= GNT_NONE;
            end
         endcase
      end
   end

   // Owner-to-slave mux and ack/err steering; everything is quiet outside OWN.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_addr_o = '0;
      s_data_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (r_state)
         OWN0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            m0_ack_o = s_ack_i;
            m0_err_o = w_fire;
         end
         OWN1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            m1_ack_o = s_ack_i;
            m1_err_o = w_fire;
         end
         default: ;
      endcase
   end

   assign m0_data_o = s_data_i;
   assign m1_data_o = s_data_i;
   assign grant_o   = r_grant;
   assign timeout_o = w_fire;

endmodule
`default_nettype wire

// File: tb/tb_wb_dual_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_dual_master_arbiter
// Description : Directed self-checking bench for wb_dual_master_arbiter with
//               an 8-cycle watchdog. Expected values are hand-derived.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_dual_master_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_cyc, m0_stb, m0_we;
   logic [3:0]  m0_sel;
   logic [31:0] m0_addr, m0_wdat, m0_rdat;
   logic        m0_ack, m0_err;
   logic        m1_cyc, m1_stb, m1_we;
   logic [3:0]  m1_sel;
   logic [31:0] m1_addr, m1_wdat, m1_rdat;
   logic        m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_addr, s_wdat, s_rdat;
   logic        s_ack;
   logic [1:0]  grant;
   logic        timeout;

   int n_checks = 0;
   int n_errors = 0;

   always #10 clk = ~clk;

   wb_dual_master_arbiter #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .SEL_WIDTH      (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_cyc_i  (m0_cyc),
      .m0_stb_i  (m0_stb),
      .m0_we_i   (m0_we),
      .m0_sel_i  (m0_sel),
      .m0_addr_i (m0_addr),
      .m0_data_i (m0_wdat),
      .m0_data_o (m0_rdat),
      .m0_ack_o  (m0_ack),
      .m0_err_o  (m0_err),
      .m1_cyc_i  (m1_cyc),
      .m1_stb_i  (m1_stb),
      .m1_we_i   (m1_we),
      .m1_sel_i  (m1_sel),
      .m1_addr_i (m1_addr),
      .m1_data_i (m1_wdat),
      .m1_data_o (m1_rdat),
      .m1_ack_o  (m1_ack),
      .m1_err_o  (m1_err),
      .s_cyc_o   (s_cyc),
      .s_stb_o   (s_stb),
      .s_we_o    (s_we),
      .s_sel_o   (s_sel),
      .s_addr_o  (s_addr),
      .s_data_o  (s_wdat),
      .s_data_i  (s_rdat),
      .s_ack_i   (s_ack),
      .grant_o   (grant),
      .timeout_o (timeout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_m0(input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] dat);
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdat = dat;
   endtask

   task automatic set_m1(input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] dat);
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdat = dat;
   endtask

   initial begin
      rst_n = 1'b0;
      s_ack = 1'b0;
      s_rdat = '0;
      set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
      set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      settle();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_s_cyc", 32'(s_cyc), 32'h0);
      chk("rst_s_stb", 32'(s_stb), 32'h0);
      chk("rst_m0_ack", 32'(m0_ack), 32'h0);
      chk("rst_m1_ack", 32'(m1_ack), 32'h0);
      chk("rst_m0_err", 32'(m0_err), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);

      // Single read by m0, slave acks two cycles after the strobe appears.
      step();
      set_m0(1, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
      settle();
      chk("t1_stb_latency", 32'(s_stb), 32'h0);
      step(); settle();
      chk("t1_stb_rise", 32'(s_stb), 32'h1);
      chk("t1_addr", s_addr, 32'h0000_0010);
      chk("t1_grant", 32'(grant), 32'h1);
      step(); settle();
      chk("t1_no_ack_yet", 32'(m0_ack), 32'h0);
      step();
      s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
      settle();
      chk("t1_m0_ack", 32'(m0_ack), 32'h1);
      chk("t1_m0_data", m0_rdat, 32'hDEAD_BEEF);
      chk("t1_m1_ack", 32'(m1_ack), 32'h0);
      step();
      s_ack = 1'b0;
      set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
      settle();
      chk("t1_ack_one_cycle", 32'(m0_ack), 32'h0);
      chk("t1_grant_held", 32'(grant), 32'h1);
      step(); settle();
      chk("t1_grant_drain", 32'(grant), 32'h0);
      step();

      // Reset so the next contention starts from last_grant = M1.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;

      // Contention: m0 read 0x100 and m1 write 0x2000 in the same cycle.
      set_m0(1, 1, 0, 4'hF, 32'h0000_0100, 32'h0);
      set_m1(1, 1, 1, 4'hF, 32'h0000_2000, 32'h1234_5678);
      step(); settle();
      chk("t2_grant_m0", 32'(grant), 32'h1);
      chk("t2_addr_m0", s_addr, 32'h0000_0100);
      chk("t2_we_m0", 32'(s_we), 32'h0);
      s_ack = 1'b1;
      settle();
      chk("t2_m0_ack", 32'(m0_ack), 32'h1);
      chk("t2_m1_stalled", 32'(m1_ack), 32'h0);
      step();
      s_ack = 1'b0;
      set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
      settle();
      chk("t2_cyc_fall", 32'(s_cyc), 32'h0);
      step(); settle();
      chk("t2_drain_grant", 32'(grant), 32'h0);
      step(); settle();
      chk("t2_idle_grant", 32'(grant), 32'h0);
      chk("t2_idle_cyc", 32'(s_cyc), 32'h0);
      step(); settle();
      chk("t2_grant_m1", 32'(grant), 32'h2);
      chk("t2_we_m1", 32'(s_we), 32'h1);
      chk("t2_addr_m1", s_addr, 32'h0000_2000);
      chk("t2_wdata_m1", s_wdat, 32'h1234_5678);
      chk("t2_sel_m1", 32'(s_sel), 32'hF);
      s_ack = 1'b1;
      settle();
      chk("t2_m1_ack", 32'(m1_ack), 32'h1);
      chk("t2_m0_ack_off", 32'(m0_ack), 32'h0);
      step();
      s_ack = 1'b0;
      set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      set_m0(1, 1, 0, 4'hF, 32'h0000_0104, 32'h0);
      set_m1(1, 1, 0, 4'hF, 32'h0000_2004, 32'h0);
      step();
      step(); settle();
      chk("t2_rr_back_to_m0", 32'(grant), 32'h1);

      // Abort: m0 drops cyc without an ack; m1 withdraws too.
      step();
      set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
      set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
      settle();
      chk("t2_abort_cyc", 32'(s_cyc), 32'h0);
      chk("t2_abort_stb", 32'(s_stb), 32'h0);
      step();
      step();

      // Lock: m1 bursts 0x3000/0x3004/0x3008 while m0 waits.
      set_m1(1, 1, 0, 4'hF, 32'h0000_3000, 32'h0);
      step();
      set_m0(1, 1, 0, 4'hF, 32'h0000_0040, 32'h0);
      s_ack = 1'b1;
      settle();
      chk("t3_grant_m1", 32'(grant), 32'h2);
      chk("t3_addr0", s_addr, 32'h0000_3000);
      chk("t3_m1_ack", 32'(m1_ack), 32'h1);
      chk("t3_m0_no_ack", 32'(m0_ack), 32'h0);
      step();
      s_ack = 1'b0;
      m1_stb = 1'b0;
      settle();
      chk("t3_lock_gap", 32'(grant), 32'h2);
      step();
      m1_stb = 1'b1; m1_addr = 32'h0000_3004; s_ack = 1'b1;
      settle();
      chk("t3_addr1", s_addr, 32'h0000_3004);
      chk("t3_lock1", 32'(grant), 32'h2);
      step();
      m1_addr = 32'h0000_3008;
      settle();
      chk("t3_addr2", s_addr, 32'h0000_3008);
      chk("t3_m0_still_waiting", 32'(m0_ack), 32'h0);
      step();
      s_ack = 1'b0;
      set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
      settle();
      chk("t3_grant_at_release", 32'(grant), 32'h2);
      chk("t3_cyc_release", 32'(s_cyc), 32'h0);
      step();
      step();
      step(); settle();
      chk("t3_m0_served", 32'(grant), 32'h1);
      chk("t3_m0_addr", s_addr, 32'h0000_0040);

      // Watchdog: the slave never acks m0; this is stalled cycle 1.
      set_m1(1, 1, 0, 4'hF, 32'h0000_5000, 32'h0);
      settle();
      for (int k = 1; k <= 7; k++) begin
         chk($sformatf("t4_no_timeout_c%0d", k), 32'(timeout), 32'h0);
         step(); settle();
      end
      chk("t4_m0_err", 32'(m0_err), 32'h1);
      chk("t4_timeout", 32'(timeout), 32'h1);
      chk("t4_m0_ack", 32'(m0_ack), 32'h0);
      chk("t4_m1_err", 32'(m1_err), 32'h0);
      step();
      set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
      settle();
      chk("t4_cyc_forced", 32'(s_cyc), 32'h0);
      chk("t4_stb_forced", 32'(s_stb), 32'h0);
      chk("t4_grant_drain", 32'(grant), 32'h0);
      chk("t4_timeout_pulse", 32'(timeout), 32'h0);
      step();
      step(); settle();
      chk("t4_m1_granted", 32'(grant), 32'h2);

      // Ack on the 8th stalled cycle of m1: ack wins, no error.
      for (int k = 1; k <= 7; k++) begin
         chk($sformatf("t5_no_err_c%0d", k), 32'(m1_err), 32'h0);
         step(); settle();
      end
      s_ack = 1'b1;
      settle();
      chk("t5_m1_ack", 32'(m1_ack), 32'h1);
      chk("t5_m1_err", 32'(m1_err), 32'h0);
      chk("t5_timeout", 32'(timeout), 32'h0);
      step();
      s_ack = 1'b0;
      set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      step();

      // Reset while m1 owns the bus and waits; a late ack must be dropped.
      set_m1(1, 1, 0, 4'hF, 32'h0000_6000, 32'h0);
      step(); settle();
      chk("t6_grant_m1", 32'(grant), 32'h2);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      s_ack = 1'b1;
      settle();
      chk("t6_cyc_after_rst", 32'(s_cyc), 32'h0);
      chk("t6_grant_after_rst", 32'(grant), 32'h0);
      chk("t6_late_ack_dropped", 32'(m1_ack), 32'h0);
      step();
      s_ack = 1'b0;
      set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
